// File: rtl/sw_mem_writer_if.sv
// Write-port bundle between the switch/button front end and the pattern RAM.
// The slave side is the writer block; the master side drives buttons/switches
// and observes the RAM write port.
interface sw_mem_writer_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          btn_wr;
    logic          btn_clr;
    logic [DW-1:0] sw;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_ptr;
    logic          busy;
    logic          wrapped;

    modport slave (
        input  btn_wr, btn_clr, sw,
        output wr_en, wr_addr, wr_data, wr_ptr, busy, wrapped
    );

    modport master (
        output btn_wr, btn_clr, sw,
        input  wr_en, wr_addr, wr_data, wr_ptr, busy, wrapped
    );
endinterface

// File: rtl/sw_mem_writer.sv
// Fills the LED pattern RAM from board switches. A debounced btn_wr press
// writes sw to the next address; a debounced btn_clr press sweeps every
// address to FILL.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a press; a write press emits one strobe
//   S_CLEAR | one strobe per cycle to every address, FILL data
module sw_mem_writer #(
    parameter int            AW        = 8,
    parameter int            DW        = 8,
    parameter int            DB_CYCLES = 500000,
    parameter logic [DW-1:0] FILL      = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    sw_mem_writer_if.slave     bus
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    // Index 0 is btn_wr, index 1 is btn_clr.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db_lvl;
    logic [1:0]    db_prev;
    logic [1:0]    press;
    logic [CW-1:0] db_cnt [2];

    state_t        state, state_n;
    logic          wr_en_q,   wr_en_n;
    logic [AW-1:0] wr_addr_q, wr_addr_n;
    logic [DW-1:0] wr_data_q, wr_data_n;
    logic [AW-1:0] wr_ptr_q,  wr_ptr_n;
    logic          busy_q,    busy_n;
    logic          wrapped_q, wrapped_n;

    assign btn_raw = {bus.btn_clr, bus.btn_wr};

    // Two-flop synchroniser for the asynchronous buttons; released level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce: the level only changes after the synced input has differed
    // from it for DB_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_lvl <= '1;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press event: one-cycle pulse on a debounced falling edge only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_prev <= '1;
            press   <= '0;
        end else begin
            db_prev <= db_lvl;
            press   <= db_prev & ~db_lvl;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_ptr_q  <= '0;
            busy_q    <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state     <= state_n;
            wr_en_q   <= wr_en_n;
            wr_addr_q <= wr_addr_n;
            wr_data_q <= wr_data_n;
            wr_ptr_q  <= wr_ptr_n;
            busy_q    <= busy_n;
            wrapped_q <= wrapped_n;
        end
    end

    // Next state and next output values; clear beats write, and presses seen
    // during a sweep are simply dropped. The sweep index is wr_addr itself.
    always_comb begin
        state_n   = state;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr_q;
        wr_data_n = wr_data_q;
        wr_ptr_n  = wr_ptr_q;
        busy_n    = busy_q;
        wrapped_n = wrapped_q;
        case (state)
            S_IDLE: begin
                if (press[1]) begin
                    state_n   = S_CLEAR;
                    busy_n    = 1'b1;
                    wr_en_n   = 1'b1;
                    wr_addr_n = '0;
                    wr_data_n = FILL;
                end else if (press[0]) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = wr_ptr_q;
                    wr_data_n = bus.sw;
                    wr_ptr_n  = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == {AW{1'b1}}) wrapped_n = 1'b1;
                end
            end
            S_CLEAR: begin
                if (wr_addr_q == {AW{1'b1}}) begin
                    state_n   = S_IDLE;
                    busy_n    = 1'b0;
                    wr_ptr_n  = '0;
                    wrapped_n = 1'b0;
                end else begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = wr_addr_q + 1'b1;
                    wr_data_n = FILL;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_ptr  = wr_ptr_q;
    assign bus.busy    = busy_q;
    assign bus.wrapped = wrapped_q;
endmodule

// File: tb/tb_sw_mem_writer.sv
// Directed bench for sw_mem_writer with a short debounce window.
module tb_sw_mem_writer;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int DB = 4;
    localparam logic [DW-1:0] FILL = 8'hA5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    sw_mem_writer_if #(.AW(AW), .DW(DW)) bus ();

    sw_mem_writer #(.AW(AW), .DW(DW), .DB_CYCLES(DB), .FILL(FILL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    // Write log captured mid-cycle.
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            wc_q[$];
    int            busy_cnt;

    always @(negedge clk) begin
        if (rst_n && bus.wr_en) begin
            wa_q.push_back(bus.wr_addr);
            wd_q.push_back(bus.wr_data);
            wc_q.push_back(cyc);
        end
        if (rst_n && bus.busy) busy_cnt++;
    end

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wc_q.delete(); busy_cnt = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        step(2);
        #4 rst_n = 1'b1;
        step(1);
    endtask

    task automatic press_wr(input logic [DW-1:0] v);
        bus.sw = v;
        bus.btn_wr = 1'b0;
        step(12);
        bus.btn_wr = 1'b1;
        step(12);
    endtask

    task automatic test_reset();
        bus.btn_wr = 1'b1; bus.btn_clr = 1'b1; bus.sw = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_ptr, bus.busy, bus.wrapped} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%b addr=%h data=%h ptr=%h busy=%b wrap=%b want all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_ptr, bus.busy, bus.wrapped);
        end
        @(posedge clk); #5 rst_n = 1'b1;
        clear_log();
        step(12);
        n_cmp++;
        if (wa_q.size() !== 0) begin
            n_err++;
            $display("FAIL reset_idle_no_write: got %0d writes want 0", wa_q.size());
        end
    endtask

    task automatic test_single_write();
        int k;
        clear_log();
        bus.sw = 8'h3C;
        @(posedge clk); #1;
        bus.btn_wr = 1'b0;
        k = cyc;
        step(20);
        bus.btn_wr = 1'b1;
        step(12);
        n_cmp++;
        if (wa_q.size() !== 1) begin
            n_err++; $display("FAIL single_count: got %0d writes want 1", wa_q.size());
        end
        n_cmp++;
        if (wc_q[0] !== k + 8) begin
            n_err++; $display("FAIL single_latency: got edge %0d want %0d", wc_q[0], k + 8);
        end
        n_cmp++;
        if (wa_q[0] !== 3'd0 || wd_q[0] !== 8'h3C) begin
            n_err++; $display("FAIL single_addr_data: got %h/%h want 0/3c", wa_q[0], wd_q[0]);
        end
        n_cmp++;
        if (bus.wr_ptr !== 3'd1) begin
            n_err++; $display("FAIL single_ptr: got %0d want 1", bus.wr_ptr);
        end
    endtask

    task automatic test_bounce();
        clear_log();
        bus.sw = 8'h5A;
        bus.btn_wr = 1'b0; step(2);
        bus.btn_wr = 1'b1; step(1);
        bus.btn_wr = 1'b0; step(2);
        bus.btn_wr = 1'b1; step(12);
        n_cmp++;
        if (wa_q.size() !== 0) begin
            n_err++; $display("FAIL bounce_no_write: got %0d writes want 0", wa_q.size());
        end
        bus.btn_wr = 1'b0; step(10);
        bus.btn_wr = 1'b1; step(12);
        n_cmp++;
        if (wa_q.size() !== 1 || wa_q[0] !== 3'd1 || wd_q[0] !== 8'h5A) begin
            n_err++; $display("FAIL bounce_stable_write: got n=%0d addr=%h data=%h want n=1 addr=1 data=5a",
                              wa_q.size(), wa_q[0], wd_q[0]);
        end
        n_cmp++;
        if (bus.wr_ptr !== 3'd2) begin
            n_err++; $display("FAIL bounce_ptr: got %0d want 2", bus.wr_ptr);
        end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        clear_log();
        for (int i = 0; i < 8; i++) begin
            press_wr(8'(i + 1));
            n_cmp++;
            if (bus.wrapped !== (i == 7)) begin
                n_err++; $display("FAIL wrap_flag_%0d: got %b want %b", i, bus.wrapped, (i == 7));
            end
        end
        n_cmp++;
        if (wa_q.size() !== 8) begin
            n_err++; $display("FAIL fill_count: got %0d want 8", wa_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wa_q[i] !== 3'(i) || wd_q[i] !== 8'(i + 1)) begin
                n_err++; $display("FAIL fill_entry_%0d: got %h/%h want %h/%h", i, wa_q[i], wd_q[i], i, i + 1);
            end
        end
        n_cmp++;
        if (bus.wr_ptr !== 3'd0) begin
            n_err++; $display("FAIL fill_ptr: got %0d want 0", bus.wr_ptr);
        end
    endtask

    task automatic test_clear_sweep();
        int k;
        clear_log();
        bus.sw = 8'h11;
        @(posedge clk); #1;
        bus.btn_clr = 1'b0;
        k = cyc;
        step(3);
        bus.btn_wr = 1'b0;
        step(17);
        bus.btn_clr = 1'b1;
        bus.btn_wr = 1'b1;
        step(14);
        n_cmp++;
        if (wa_q.size() !== 8) begin
            n_err++; $display("FAIL sweep_count: got %0d writes want 8", wa_q.size());
        end
        n_cmp++;
        if (wc_q[0] !== k + 8) begin
            n_err++; $display("FAIL sweep_start: got edge %0d want %0d", wc_q[0], k + 8);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wa_q[i] !== 3'(i) || wd_q[i] !== FILL || wc_q[i] !== k + 8 + i) begin
                n_err++; $display("FAIL sweep_entry_%0d: got addr=%h data=%h edge=%0d want %h/a5/%0d",
                                  i, wa_q[i], wd_q[i], wc_q[i], i, k + 8 + i);
            end
        end
        n_cmp++;
        if (busy_cnt !== 8) begin
            n_err++; $display("FAIL sweep_busy_len: got %0d want 8", busy_cnt);
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.wrapped !== 1'b0 || bus.wr_ptr !== 3'd0) begin
            n_err++; $display("FAIL sweep_end_state: got busy=%b wrap=%b ptr=%0d want 0/0/0",
                              bus.busy, bus.wrapped, bus.wr_ptr);
        end
    endtask

    task automatic test_simultaneous_and_abort();
        bit found;
        clear_log();
        bus.sw = 8'h77;
        @(posedge clk); #1;
        bus.btn_wr = 1'b0;
        bus.btn_clr = 1'b0;
        step(20);
        bus.btn_wr = 1'b1;
        bus.btn_clr = 1'b1;
        step(12);
        n_cmp++;
        if (wa_q.size() !== 8) begin
            n_err++; $display("FAIL simul_count: got %0d writes want 8", wa_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (wd_q[i] !== FILL) begin
                n_err++; $display("FAIL simul_data_%0d: got %h want a5", i, wd_q[i]);
            end
        end

        bus.btn_clr = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus.wr_en && bus.wr_addr == 3'd3) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL abort_reach_addr3: got timeout want sweep at addr 3");
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL abort_immediate: got en=%b busy=%b want 0/0", bus.wr_en, bus.busy);
        end
        bus.btn_clr = 1'b1;
        step(2);
        rst_n = 1'b1;
        clear_log();
        step(12);
        n_cmp++;
        if (wa_q.size() !== 0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL abort_stays_idle: got n=%0d busy=%b want 0/0", wa_q.size(), bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_bounce();
        test_fill_wrap();
        test_clear_sweep();
        test_simultaneous_and_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
